quad_enc_gen: RTL and testbench

- Quadrature encoder signal generator: the transmit-side counterpart of the team's quadrature decoder (quad).
- Accepts an 8-bit target position over a valid/ready handshake.
- Steps a Gray-coded A/B pair one quarter-cycle at a time, at a programmable rate, until its internal position equals the target.
- Drives decoder benches and on-board loopback self-test on the iCEStick; A/B outputs connect directly to a decoder's quadrature inputs.

---
 rtl/quad_enc_gen.sv | 117 +++++++++++
 tb/tb_quad_enc_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_gen.sv
// rtl/quad_enc_gen.sv - quadrature A/B generator stepping toward a target position
// Optional index output enabled by defining QUAD_ENC_GEN_INDEX_EN.
module quad_enc_gen #(
    parameter int DIV_W = 16,
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] target,
    input  logic [DIV_W-1:0] period,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic             stop,
    output logic             quadA,
    output logic             quadB,
    output logic [POS_W-1:0] position,
    output logic             busy,
`ifdef QUAD_ENC_GEN_INDEX_EN
    output logic             index,
`endif
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [POS_W-1:0]   tgt_q;
    logic [DIV_W-1:0]   per_q;
    logic [DIV_W-1:0]   div;
    logic               accept;
    logic               tick;
    logic               step;
    logic               fwd;
    logic               arrive;
    logic               same;
    logic [POS_W-1:0]   diff;
    logic [POS_W-1:0]   pos_step;
    logic [POS_W-1:0]   pos_next;
    logic [DIV_W-1:0]   per_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept   = (state == IDLE) && target_valid;
        same     = (target == position);
        per_eff  = (period == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : period;
        tick     = (div == per_q - 1'b1);
        step     = (state == RUN) && !stop && tick;
        diff     = tgt_q - position;
        // Shortest path; an exact half-revolution difference resolves forward.
        fwd      = !diff[POS_W-1] || (diff == {1'b1, {(POS_W-1){1'b0}}});
        pos_step = fwd ? position + 1'b1 : position - 1'b1;
        pos_next = step ? pos_step : position;
        arrive   = step && (pos_step == tgt_q);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !same) state_next = RUN;
            RUN:  if (stop || arrive)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        target_ready = (state == IDLE);
        busy         = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q    <= '0;
            per_q    <= {{(DIV_W-1){1'b0}}, 1'b1};
            div      <= '0;
            position <= '0;
            quadA    <= 1'b0;
            quadB    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (accept && same) || arrive;
            if (accept) begin
                tgt_q <= target;
                per_q <= per_eff;
                div   <= '0;
            end else if (state == RUN) begin
                if (stop || tick) begin
                    div <= '0;
                end else begin
                    div <= div + 1'b1;
                end
            end
            // A/B follow the Gray phase of the position they are registered with.
            position <= pos_next;
            quadA    <= pos_next[1] ^ pos_next[0];
            quadB    <= pos_next[1];
        end
    end

`ifdef QUAD_ENC_GEN_INDEX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= 1'b0;
        end else begin
            index <= (pos_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// tb/tb_quad_enc_gen.sv - scoreboard bench for quad_enc_gen
// Index checks compiled in when QUAD_ENC_GEN_INDEX_EN is defined.
module tb_quad_enc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  target;
    logic [15:0] period;
    logic        target_valid;
    logic        target_ready;
    logic        stop;
    logic        quad_a;
    logic        quad_b;
    logic [7:0]  position;
    logic        busy;
    logic        done;
`ifdef QUAD_ENC_GEN_INDEX_EN
    logic        index;
`endif

    quad_enc_gen #(.DIV_W(16), .POS_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target       (target),
        .period       (period),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .stop         (stop),
        .quadA        (quad_a),
        .quadB        (quad_b),
        .position     (position),
        .busy         (busy),
`ifdef QUAD_ENC_GEN_INDEX_EN
        .index        (index),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic       a;
        logic       b;
    } step_t;

    step_t      step_q[$];
    int         done_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         since_rst = 0;
    int         acc;
    logic [7:0] model_pos = 8'd0;
    logic [7:0] prev_pos = 8'd0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] phase_ab(input logic [7:0] p);
        case (p[1:0])
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Expected step timeline for a move; lim truncates it for an aborted move.
    task automatic plan(input logic [7:0] t, input logic [15:0] p, input int a, input int lim);
        int         pe;
        int         k;
        int         d;
        logic [1:0] ab;
        step_t      s;
        pe = (p == 16'd0) ? 1 : int'(p);
        k  = 0;
        if (model_pos == t) begin
            done_q.push_back(a);
            return;
        end
        while (model_pos != t && k < lim) begin
            d = (int'(t) - int'(model_pos) + 256) % 256;
            if (d <= 128) model_pos = model_pos + 8'd1;
            else          model_pos = model_pos - 8'd1;
            k++;
            ab    = phase_ab(model_pos);
            s.cyc = a + k * pe;
            s.pos = model_pos;
            s.a   = ab[1];
            s.b   = ab[0];
            step_q.push_back(s);
            if (model_pos == t) done_q.push_back(a + k * pe);
        end
    endtask

    task automatic offer(input logic [7:0] t, input logic [15:0] p, output int a);
        chk("ready_before_offer", target_ready, 1);
        target       = t;
        period       = p;
        target_valid = 1'b1;
        @(posedge clk);
        #1;
        a            = cyc;
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0 && step_q.size() == 0 && done_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_idle", ok, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pos = position;
        end else begin
            if (position !== prev_pos) begin
                chk("step_expected", step_q.size() > 0, 1);
                if (step_q.size() > 0) begin
                    step_t e;
                    e = step_q.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_pos", position, e.pos);
                    chk("quadA", quad_a, e.a);
                    chk("quadB", quad_b, e.b);
                end
                prev_pos = position;
            end
            if (done === 1'b1) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end
`ifdef QUAD_ENC_GEN_INDEX_EN
            if (since_rst >= 1) chk("index_track", index, position == 8'd0);
`endif
        end
    end

    initial begin
        rst_n        = 1'b0;
        target       = 8'd0;
        period       = 16'd0;
        target_valid = 1'b0;
        stop         = 1'b0;
        #1;
        chk("rst_position", position, 0);
        chk("rst_quadA", quad_a, 0);
        chk("rst_quadB", quad_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", target_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_pos = 8'd0;
        @(posedge clk);
        #1;
`ifdef QUAD_ENC_GEN_INDEX_EN
        chk("index_after_reset", index, 1);
`endif

        // Forward move with period 3; target/period changes while busy must be ignored.
        offer(8'd4, 16'd3, acc);
        plan(8'd4, 16'd3, acc, 1000);
        target = 8'h55;
        period = 16'd1;
        chk("busy_in_move", busy, 1);
        chk("ready_in_move", target_ready, 0);
        wait_idle(100);

        // Reverse across the wrap at one step per clock.
        offer(8'd2, 16'd0, acc);
        plan(8'd2, 16'd0, acc, 1000);
        wait_idle(50);
        offer(8'hFE, 16'd0, acc);
        plan(8'hFE, 16'd0, acc, 1000);
        wait_idle(50);
        chk("pos_fe", position, 8'hFE);

        // Back to 0, then a half-revolution move resolves forward.
        offer(8'd0, 16'd1, acc);
        plan(8'd0, 16'd1, acc, 1000);
        wait_idle(50);
        offer(8'h80, 16'd0, acc);
        plan(8'h80, 16'd0, acc, 1000);
        wait_idle(300);
        chk("pos_80", position, 8'h80);
        chk("ab_80", {quad_a, quad_b}, 2'b00);

        // Target equal to current position.
        offer(8'h80, 16'd7, acc);
        plan(8'h80, 16'd7, acc, 1000);
        chk("busy_same_target", busy, 0);
        wait_idle(20);

        offer(8'd0, 16'd0, acc);
        plan(8'd0, 16'd0, acc, 1000);
        wait_idle(300);
`ifdef QUAD_ENC_GEN_INDEX_EN
        chk("index_at_zero", index, 1);
`endif

        // Stop coincident with the third tick.
        offer(8'd10, 16'd5, acc);
        plan(8'd10, 16'd5, acc, 2);
        repeat (14) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        chk("stop_pos", position, 2);
        chk("stop_busy", busy, 0);
        chk("stop_ready", target_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("stop_hold_pos", position, 2);
        chk("stop_steps_left", step_q.size(), 0);
        chk("stop_done_left", done_q.size(), 0);

        // Asynchronous reset mid-move at position 6.
        offer(8'd10, 16'd2, acc);
        plan(8'd10, 16'd2, acc, 1000);
        begin
            int found;
            found = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                #1;
                if (position == 8'd6) begin
                    found = 1;
                    break;
                end
            end
            chk("reach_pos6", found, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_position", position, 0);
        chk("arst_quadA", quad_a, 0);
        chk("arst_quadB", quad_b, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", target_ready, 1);
        step_q.delete();
        done_q.delete();
        model_pos = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_position", position, 0);
        chk("post_rst_ready", target_ready, 1);
`ifdef QUAD_ENC_GEN_INDEX_EN
        chk("post_rst_index", index, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
